// File: rtl/byte_packer_pkg.sv
// Shared types, widths and helpers for the byte packer.
package byte_packer_pkg;

  localparam int unsigned NBYTES    = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DATA_W    = NBYTES * BYTE_W;
  localparam int unsigned RES_W     = (NBYTES - 1) * BYTE_W;
  localparam int unsigned MERGE_W   = (2 * NBYTES - 1) * BYTE_W;
  localparam int unsigned RCNT_W    = 2;
  localparam int unsigned TOTAL_W   = 3;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FLUSH_PEND
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [NBYTES-1:0] be;
  } out_word_t;

  // Low-contiguous byte mask with n bytes set: (1<<n)-1.
  function automatic logic [NBYTES-1:0] mask_from_count(input logic [TOTAL_W-1:0] n);
    logic [NBYTES:0] one_hot;
    one_hot = (NBYTES + 1)'(1) << n;
    return NBYTES'(one_hot - (NBYTES + 1)'(1));
  endfunction

endpackage

// File: rtl/byte_packer_compactor.sv
// Combinational merge of residual bytes with the valid bytes of a new word.
module byte_packer_compactor
  import byte_packer_pkg::*;
(
  input  logic [RES_W-1:0]   res_data,
  input  logic [RCNT_W-1:0]  res_cnt,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [NBYTES-1:0]  in_be,
  output logic [MERGE_W-1:0] merged,
  output logic [TOTAL_W-1:0] total
);

  logic [TOTAL_W-1:0] pos;

  // Residual bytes first, then valid input bytes in ascending order; unused lanes stay zero.
  always_comb begin
    merged = '0;
    pos    = TOTAL_W'(res_cnt);
    for (int i = 0; i < int'(NBYTES - 1); i++) begin
      if (RCNT_W'(i) < res_cnt) begin
        merged[i*BYTE_W +: BYTE_W] = res_data[i*BYTE_W +: BYTE_W];
      end
    end
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (in_be[i]) begin
        merged[BYTE_W * 32'(pos) +: BYTE_W] = in_data[i*BYTE_W +: BYTE_W];
        pos = pos + TOTAL_W'(1);
      end
    end
    total = pos;
  end

endmodule

// File: rtl/byte_packer.sv
// Byte packer: compacts byte-masked words into dense 32-bit words with flush.
// Optional statistics counters are enabled with BYTE_PACKER_STATS_EN.
module byte_packer
  import byte_packer_pkg::*;
`ifdef BYTE_PACKER_STATS_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [NBYTES-1:0] IN_BE,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [NBYTES-1:0] OUT_BE
`ifdef BYTE_PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0]  WORD_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
`endif
);

  state_e             state_q, state_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               out_valid_q, out_valid_d;
  out_word_t          out_q, out_d;

  logic [MERGE_W-1:0] merged;
  logic [TOTAL_W-1:0] total;
  logic               in_ready_c;
  logic               accept_c;

  byte_packer_compactor u_compactor (
    .res_data (res_q),
    .res_cnt  (rcnt_q),
    .in_data  (IN_DATA),
    .in_be    (IN_BE),
    .merged   (merged),
    .total    (total)
  );

  // Accept only when the slot frees this cycle and no flush is waiting for it.
  assign in_ready_c = !RESET && (!out_valid_q || OUT_READY) && (state_q != FLUSH_PEND);
  assign accept_c   = IN_VALID && in_ready_c;

  // Next-state: merge accepted bytes, then service any flush request.
  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    rcnt_d       = rcnt_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q && !OUT_READY;
    out_d        = out_valid_d ? out_q : '0;

    if (accept_c) begin
      if (total >= TOTAL_W'(NBYTES)) begin
        out_d.data  = merged[DATA_W-1:0];
        out_d.be    = '1;
        out_valid_d = 1'b1;
        res_d       = merged[MERGE_W-1:DATA_W];
        rcnt_d      = RCNT_W'(total - TOTAL_W'(NBYTES));
      end else begin
        res_d  = merged[RES_W-1:0];
        rcnt_d = RCNT_W'(total);
      end
    end

    if (FLUSH || flush_pend_q) begin
      if (rcnt_d == '0) begin
        flush_pend_d = 1'b0;
      end else if (!out_valid_d) begin
        out_d.data   = DATA_W'(res_d);
        out_d.be     = mask_from_count(TOTAL_W'(rcnt_d));
        out_valid_d  = 1'b1;
        res_d        = '0;
        rcnt_d       = '0;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end

    if (rcnt_d == '0) begin
      state_d = EMPTY;
    end else if (flush_pend_d) begin
      state_d = FLUSH_PEND;
    end else begin
      state_d = PARTIAL;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= EMPTY;
      res_q        <= '0;
      rcnt_q       <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      res_q        <= res_d;
      rcnt_q       <= rcnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  assign IN_READY  = in_ready_c;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_q.data;
  assign OUT_BE    = out_q.be;

`ifdef BYTE_PACKER_STATS_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Count full and partial words as they leave the output slot.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && OUT_READY) begin
      if (out_q.be == '1) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      word_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign WORD_CNT  = word_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// Directed table-driven bench for byte_packer (optionally with BYTE_PACKER_STATS_EN).
module tb_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_be;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_be;
`ifdef BYTE_PACKER_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  byte_packer dut (
    .CLK       (clk),
    .RESET     (rst),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .IN_BE     (in_be),
    .FLUSH     (flush),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .OUT_BE    (out_be)
`ifdef BYTE_PACKER_STATS_EN
    ,
    .WORD_CNT  (word_cnt),
    .FLUSH_CNT (flush_cnt)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] data;
    logic [3:0]  be;
    logic        fl;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [31:0] od;
    logic [3:0]  obe;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] data, input logic [3:0] be,
                     input logic fl, input logic ordy, input logic ir,
                     input logic ov, input logic [31:0] od, input logic [3:0] obe);
    vec_t v;
    v.iv = iv; v.data = data; v.be = be; v.fl = fl; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.obe = obe;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [31:0] data, input logic [3:0] be,
                       input logic fl, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = data;
    in_be     = be;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [31:0] od,
                           input logic [3:0] obe);
    check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, " out_data"}, out_data, od);
    check({tag, " out_be"}, 32'(out_be), 32'(obe));
  endtask

  int   exp_words  = 0;
  int   exp_flushs = 0;
  logic prev_ov    = 1'b0;
  logic [3:0] prev_be = 4'h0;

  initial begin
    // Two-step pack
    add(1, 32'h0000ABCD, 4'b0011, 0, 1,  1, 0, 32'h0,        4'h0);
    add(1, 32'h00000FFF, 4'b0011, 0, 1,  1, 1, 32'h0FFFABCD, 4'hF);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    // Overflow residual then flush
    add(1, 32'h00332211, 4'b0111, 0, 1,  1, 0, 32'h0,        4'h0);
    add(1, 32'h77665544, 4'b1111, 0, 1,  1, 1, 32'h44332211, 4'hF);
    add(0, 32'h0,        4'b0000, 1, 1,  1, 1, 32'h00776655, 4'h7);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    // Backpressure: held word stable for 5 cycles, then back-to-back reload
    add(1, 32'h44332211, 4'b1111, 0, 0,  1, 1, 32'h44332211, 4'hF);
    for (int i = 0; i < 5; i++)
      add(1, 32'h88776655, 4'b1111, 0, 0,  0, 1, 32'h44332211, 4'hF);
    add(1, 32'h88776655, 4'b1111, 0, 1,  1, 1, 32'h88776655, 4'hF);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    // Flush contention with residual AA,BB behind a held word
    add(1, 32'h00002211, 4'b0011, 0, 1,  1, 0, 32'h0,        4'h0);
    add(1, 32'hBBAA4433, 4'b1111, 0, 0,  1, 1, 32'h44332211, 4'hF);
    add(0, 32'h0,        4'b0000, 1, 0,  0, 1, 32'h44332211, 4'hF);
    add(1, 32'h12345678, 4'b1111, 0, 0,  0, 1, 32'h44332211, 4'hF);
    add(1, 32'h12345678, 4'b1111, 0, 1,  0, 1, 32'h0000BBAA, 4'h3);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    add(0, 32'h0,        4'b0000, 1, 1,  1, 0, 32'h0,        4'h0);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    // Empty byte mask is accepted and contributes nothing
    add(1, 32'hDEADBEEF, 4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    add(1, 32'h44332211, 4'b1111, 0, 1,  1, 1, 32'h44332211, 4'hF);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    // Sparse masks
    add(1, 32'hAA00BB00, 4'b1010, 0, 1,  1, 0, 32'h0,        4'h0);
    add(1, 32'h00DD00CC, 4'b0101, 0, 1,  1, 1, 32'hDDCCAABB, 4'hF);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    // Flush with same-cycle accept below a full word
    add(1, 32'h00000077, 4'b0001, 1, 1,  1, 1, 32'h00000077, 4'h1);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);
    // Flush with same-cycle accept that completes a word: leftover goes next
    add(1, 32'h00332211, 4'b0111, 0, 1,  1, 0, 32'h0,        4'h0);
    add(1, 32'h77665544, 4'b1111, 1, 1,  1, 1, 32'h44332211, 4'hF);
    add(1, 32'h99999999, 4'b1111, 0, 1,  0, 1, 32'h00776655, 4'h7);
    add(0, 32'h0,        4'b0000, 0, 1,  1, 0, 32'h0,        4'h0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_be = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 32'h0, 4'h0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("idle%0d in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check_out($sformatf("idle%0d", i), 1'b0, 32'h0, 4'h0);
      @(negedge clk);
    end

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].iv, vecs[k].data, vecs[k].be, vecs[k].fl, vecs[k].ordy);
      #1;
      check($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].ir));
      if (prev_ov && vecs[k].ordy) begin
        if (prev_be == 4'hF) exp_words++;
        else exp_flushs++;
      end
      prev_ov = vecs[k].ov;
      prev_be = vecs[k].obe;
      @(posedge clk); #1;
      check_out($sformatf("v%0d", k), vecs[k].ov, vecs[k].od, vecs[k].obe);
    end

`ifdef BYTE_PACKER_STATS_EN
    check("word_cnt", 32'(word_cnt), 32'(exp_words));
    check("flush_cnt", 32'(flush_cnt), 32'(exp_flushs));
`endif

    // Reset mid-operation with three residual bytes and a held word
    drive(1, 32'h00332211, 4'b0111, 0, 0);
    drive(1, 32'h77665544, 4'b1111, 0, 0);
    @(posedge clk); #1;
    check_out("pre-reset", 1'b1, 32'h44332211, 4'hF);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    check("midrst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check_out("midrst", 1'b0, 32'h0, 4'h0);
`ifdef BYTE_PACKER_STATS_EN
    check("midrst word_cnt", 32'(word_cnt), 32'd0);
    check("midrst flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check_out("postrst flush", 1'b0, 32'h0, 4'h0);
    drive(1, 32'hD4C3B2A1, 4'b1111, 0, 1);
    @(posedge clk); #1;
    check_out("postrst word", 1'b1, 32'hD4C3B2A1, 4'hF);
    drive(0, 32'h0, 4'b0000, 0, 1);
    @(posedge clk); #1;
    check_out("postrst drain", 1'b0, 32'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
